// File: rtl/mar_ram_pkg.sv
// mar_ram_pkg: shared state encoding, default widths and parity helper for the MAR/RAM controller.
package mar_ram_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_PROG  = 2'd3
  } state_t;
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/mar_ram_mem.sv
// mar_ram_mem: single-port synchronous RAM with registered read; contents are never reset.
module mar_ram_mem #(
  parameter int DW     = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mar_ram_ctrl.sv
// mar_ram_ctrl: MAR + internal RAM + control FSM (IDLE/READ/WRITE/PROG) with sticky error.
// Define MAR_PARITY_EN to store and check an even-parity bit per RAM word.
module mar_ram_ctrl
  import mar_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MI,
  input  logic              RI,
  input  logic              RO,
  input  logic              INC,
  input  logic              PRGM,
  input  logic              PRGM_WE,
  input  logic [DATA_W-1:0] PRGM_IN,
  input  logic [DATA_W-1:0] BUS_IN,
  output logic [DATA_W-1:0] BUS_OUT,
  output logic              BUS_OE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              BUSY,
  output logic              ERR
);
`ifdef MAR_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  state_t            state, state_n;
  logic [ADDR_W-1:0] mar, mar_n, mar_inc;
  logic              err_q, err_n, we, re, par_err;
  logic [DATA_W-1:0] wd;
  logic [MW-1:0]     mem_wd, rd_q;
`ifdef MAR_PARITY_EN
  assign mem_wd  = {even_par(64'(wd)), wd};
  assign par_err = (state == ST_READ) && (rd_q[DATA_W] != even_par(64'(rd_q[DATA_W-1:0])));
`else
  assign mem_wd  = wd;
  assign par_err = 1'b0;
`endif
  mar_ram_mem #(.DW(MW), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk(CLK), .we(we), .re(re), .addr(mar), .wdata(mem_wd), .rdata(rd_q)
  );
  assign mar_inc = (mar == ADDR_W'(DEPTH - 1)) ? '0 : mar + ADDR_W'(1);
  always_comb begin
    state_n = state;
    mar_n   = mar;
    err_n   = err_q;
    we      = 1'b0;
    re      = 1'b0;
    wd      = BUS_IN;
    case (state)
      ST_IDLE: begin
        err_n = err_q | ($countones({MI, RI, RO, INC}) > 1);
        if (PRGM) begin
          state_n = ST_PROG;
          mar_n   = '0;
        end else if (RO) begin
          state_n = ST_READ;
          re      = 1'b1;
        end else if (RI) begin
          state_n = ST_WRITE;
          we      = 1'b1;
        end else if (MI) begin
          if (DEPTH < 2**ADDR_W && int'(BUS_IN[ADDR_W-1:0]) >= DEPTH) err_n = 1'b1;
          else mar_n = BUS_IN[ADDR_W-1:0];
        end else if (INC) mar_n = mar_inc;
      end
      ST_READ: begin
        state_n = ST_IDLE;
        err_n   = err_q | par_err;
      end
      ST_WRITE: state_n = ST_IDLE;
      ST_PROG: begin
        wd      = PRGM_IN;
        we      = PRGM_WE;
        mar_n   = PRGM_WE ? mar_inc : mar;
        state_n = PRGM ? ST_PROG : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      mar   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      mar   <= mar_n;
      err_q <= err_n;
    end
  end
  assign BUS_OE  = state == ST_READ;
  assign BUS_OUT = BUS_OE ? rd_q[DATA_W-1:0] : '0;
  assign BUSY    = state == ST_READ || state == ST_WRITE;
  assign ADDR    = mar;
  assign ERR     = err_q | par_err;
endmodule

// File: tb/tb_mar_ram_ctrl.sv
// tb_mar_ram_ctrl: directed self-checking bench for mar_ram_ctrl using immediate assertions.
module tb_mar_ram_ctrl;
  logic       CLK = 1'b0, RESET = 1'b1;
  logic       MI = 0, RI = 0, RO = 0, INC = 0, PRGM = 0, PRGM_WE = 0;
  logic [7:0] PRGM_IN = '0, BUS_IN = '0, BUS_OUT;
  logic       BUS_OE, BUSY, ERR;
  logic [3:0] ADDR;
  int         n_cmp = 0, n_bad = 0;
  mar_ram_ctrl dut (
    .CLK(CLK), .RESET(RESET), .MI(MI), .RI(RI), .RO(RO), .INC(INC), .PRGM(PRGM),
    .PRGM_WE(PRGM_WE), .PRGM_IN(PRGM_IN), .BUS_IN(BUS_IN), .BUS_OUT(BUS_OUT),
    .BUS_OE(BUS_OE), .ADDR(ADDR), .BUSY(BUSY), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #12;
    chk("rst_addr", 32'(ADDR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_oe", 32'(BUS_OE), 0);
    chk("rst_bus", 32'(BUS_OUT), 0);
    RESET = 0;
    MI = 1; BUS_IN = 8'h05; tick; MI = 0;
    chk("mi_addr", 32'(ADDR), 5);
    chk("mi_busy", 32'(BUSY), 0);
    chk("mi_err", 32'(ERR), 0);
    PRGM = 1; tick;
    chk("prog_entry_addr", 32'(ADDR), 0);
    chk("prog_busy", 32'(BUSY), 0);
    PRGM_WE = 1; PRGM_IN = 8'h50; tick;
    PRGM_IN = 8'hA0; tick;
    PRGM_IN = 8'h3C; tick;
    PRGM_WE = 0;
    chk("prog_addr3", 32'(ADDR), 3);
    RO = 1; MI = 1; BUS_IN = 8'h09; tick; RO = 0; MI = 0;
    chk("prog_ignores_cmd", 32'(ADDR), 3);
    chk("prog_no_err", 32'(ERR), 0);
    PRGM = 0; tick;
    chk("prog_exit_addr", 32'(ADDR), 3);
    chk("prog_exit_busy", 32'(BUSY), 0);
    MI = 1; BUS_IN = 8'h01; tick; MI = 0;
    RO = 1; tick; RO = 0;
    chk("rd1_bus", 32'(BUS_OUT), 32'hA0);
    chk("rd1_oe", 32'(BUS_OE), 1);
    chk("rd1_busy", 32'(BUSY), 1);
    tick;
    chk("rd1_oe_drop", 32'(BUS_OE), 0);
    chk("rd1_busy_drop", 32'(BUSY), 0);
    chk("rd1_bus_drop", 32'(BUS_OUT), 0);
    MI = 1; BUS_IN = 8'h0F; tick; MI = 0;
    INC = 1; tick; INC = 0;
    chk("inc_wrap", 32'(ADDR), 0);
    RI = 1; BUS_IN = 8'h77; tick; RI = 0;
    chk("wr_busy", 32'(BUSY), 1);
    INC = 1; MI = 1; BUS_IN = 8'h04; tick; INC = 0; MI = 0;
    chk("busy_ignore_addr", 32'(ADDR), 0);
    chk("busy_ignore_err", 32'(ERR), 0);
    chk("wr_done_busy", 32'(BUSY), 0);
    RO = 1; tick; RO = 0;
    chk("rd_77", 32'(BUS_OUT), 32'h77);
    tick;
    MI = 1; BUS_IN = 8'h02; tick; MI = 0;
    RO = 1; tick; RO = 0;
    chk("rd_3c", 32'(BUS_OUT), 32'h3C);
    tick;
    chk("err_still_clear", 32'(ERR), 0);
    MI = 1; RO = 1; BUS_IN = 8'h09; tick; MI = 0; RO = 0;
    chk("illegal_read_data", 32'(BUS_OUT), 32'h3C);
    chk("illegal_read_oe", 32'(BUS_OE), 1);
    chk("illegal_addr_kept", 32'(ADDR), 2);
    chk("illegal_err", 32'(ERR), 1);
    tick; tick;
    chk("err_sticky", 32'(ERR), 1);
    RO = 1; tick; RO = 0;
    chk("pre_rst_oe", 32'(BUS_OE), 1);
    #1 RESET = 1;
    #1;
    chk("async_rst_oe", 32'(BUS_OE), 0);
    chk("async_rst_addr", 32'(ADDR), 0);
    chk("async_rst_err", 32'(ERR), 0);
    chk("async_rst_busy", 32'(BUSY), 0);
    tick;
    RESET = 0;
    MI = 1; BUS_IN = 8'h01; tick; MI = 0;
`ifdef MAR_PARITY_EN
    dut.u_mem.mem[1][8] = ~dut.u_mem.mem[1][8];
`endif
    RO = 1; tick; RO = 0;
    chk("rd_after_rst", 32'(BUS_OUT), 32'hA0);
`ifdef MAR_PARITY_EN
    chk("parity_err", 32'(ERR), 1);
`else
    chk("no_parity_err", 32'(ERR), 0);
`endif
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mar_ram_ctrl.md
Name: mar_ram_ctrl

Overview:
- Parametrised successor to the fixed 4-bit memory address register and 16-byte RAM pair.
- Combines the MAR, an internal synchronous RAM and a small control FSM. The FSM serialises bus loads, RAM reads and RAM writes, plus a programmer-driven load mode with address auto-increment.
- Sits between the shared 8-bit bus mux and the controller/sequencer. It reports busy/error status so the sequencer can stall.

Parameters:
- ADDR_W, 4, MAR and RAM address width.
- DATA_W, 8, bus and RAM word width. Must be ≥ ADDR_W.
- DEPTH, 16, number of RAM words. Must be ≤ 2**ADDR_W.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- MI  in  1  load MAR from BUS_IN[ADDR_W-1:0]
- RI  in  1  write BUS_IN to RAM[MAR]
- RO  in  1  read RAM[MAR] onto BUS_OUT
- INC  in  1  increment MAR (run mode)
- PRGM  in  1  programming mode select (level)
- PRGM_WE  in  1  one-cycle write strobe in programming mode
- PRGM_IN  in  DATA_W  programmer data word
- BUS_IN  in  DATA_W  shared bus input
- BUS_OUT  out  DATA_W  RAM read data
- BUS_OE  out  1  BUS_OUT valid / drive request
- ADDR  out  ADDR_W  current MAR value
- BUSY  out  1  FSM not in IDLE or PROG
- ERR  out  1  sticky error flag

Behaviour:
- Reset (async): MAR=0, state=IDLE, BUS_OUT=0, BUS_OE=0, BUSY=0, ERR=0. RAM contents are not reset. A reset mid-read drops BUS_OE on the same edge.
- States: IDLE, READ, WRITE, PROG.
- IDLE, command sampled each rising edge. Priority order, first match wins:
  - PRGM=1 → PROG.
  - RO=1 → READ.
  - RI=1 → WRITE.
  - MI=1 → MAR ← BUS_IN[ADDR_W-1:0], stay IDLE.
  - INC=1 → MAR ← MAR+1, stay IDLE.
- Illegal command combination: more than one of MI/RI/RO/INC high in the same IDLE cycle sets ERR. The highest-priority command still executes.
- READ: RAM read registered. BUS_OUT=RAM[MAR] and BUS_OE=1 for exactly the one cycle after the RO edge; BUSY=1 that cycle. Returns to IDLE; BUS_OE drops the next cycle. Read latency is 1 cycle.
- WRITE: RAM[MAR] ← BUS_IN captured on the RI edge. The WRITE state lasts one cycle with BUSY=1, then returns to IDLE. Commands arriving while BUSY=1 are ignored; they do not set ERR.
- PROG:
  - On entry MAR is reset to 0.
  - Each PRGM_WE edge writes RAM[MAR] ← PRGM_IN, then MAR increments.
  - MI/RI/RO/INC are ignored.
  - PRGM=0 → IDLE with MAR retained.
- Wrap-around: MAR+1 at DEPTH-1 → 0 (both INC and PROG auto-increment).
- Address range: an MI load with value ≥ DEPTH sets ERR and MAR is unchanged. This applies only when DEPTH < 2**ADDR_W.
- ERR: cleared only by RESET.
- ADDR: always shows the registered MAR.

Optional Feature:
- MAR_PARITY_EN defined:
  - Each RAM word stores one extra even-parity bit, computed on every write (RI and PRGM_WE).
  - READ recomputes parity. A mismatch sets ERR in the BUS_OE cycle; data is still driven.
- Undefined: no parity storage and no check; RAM width is DATA_W.

Decomposition:
- Package mar_ram_pkg holds:
  - state enum constants ST_IDLE=2'd0, ST_READ=2'd1, ST_WRITE=2'd2, ST_PROG=2'd3;
  - default widths;
  - a parity function.
- One sub-module, mar_ram_mem: a single-port synchronous RAM with registered read, parametrised by DATA_W (+1 with parity), ADDR_W and DEPTH. The FSM and MAR stay in the top module.

Test Plan:
- Reset, then MI with BUS_IN=8'h05 → ADDR=4'h5, BUSY=0, ERR=0.
- PRGM=1 with PRGM_WE pulses carrying 8'h50, 8'hA0, 8'h3C → RAM[0..2] loaded, ADDR=3. PRGM=0 → IDLE, ADDR stays 3.
- MI 8'h01, then RO → one cycle later BUS_OUT=8'hA0 and BUS_OE=1 for exactly 1 cycle, BUSY=1 in that cycle.
- MI 8'h0F, INC → ADDR=0. RI with BUS_IN=8'h77, then RO → BUS_OUT=8'h77.
- MI and RO asserted together → read executes, ERR=1 and stays high until RESET.
- RESET asserted mid-READ → BUS_OE=0 and ADDR=0 immediately, without waiting for a clock edge. With MAR_PARITY_EN: corrupt the stored parity bit via the bench backdoor, then RO → ERR=1.
